// File: rtl/sys_bitlatch_array_if.sv
// Bus bundle for the addressable bit-latch array: the 68K-side write
// strobe, bit select and data bit, plus the latch contents and status
// returned to the system.
//
// Handshake: there is no ready/back-pressure. A write is offered by
// holding nWR low with ADDR/DIN stable; the latch takes it on the next
// rising CLK edge with CLK_EN high (level mode), or on the first such
// edge after nWR was last sampled high (edge mode).
interface sys_bitlatch_array_if #(
    parameter int ADDR_W = 3
);
    localparam int N = 1 << ADDR_W;

    logic [ADDR_W-1:0] ADDR;
    logic              DIN;
    logic              nWR;
    logic [N-1:0]      Q;
    logic              CHANGED;
    logic [ADDR_W-1:0] LAST_ADDR;

    // Address decoder / CPU side drives the write request.
    modport master (
        output ADDR,
        output DIN,
        output nWR,
        input  Q,
        input  CHANGED,
        input  LAST_ADDR
    );

    // Latch array side receives the request and returns its contents.
    modport slave (
        input  ADDR,
        input  DIN,
        input  nWR,
        output Q,
        output CHANGED,
        output LAST_ADDR
    );
endinterface

// File: rtl/sys_bitlatch_array.sv
// Addressable bit-latch array. Each write strobe sets or clears one bit
// of Q selected by ADDR, with the value taken from DIN. Reset loads a
// per-bit image, and a write present during reset is merged into that
// image (demux). In edge mode a held-low strobe commits only once.
// Every register advances only on CLK edges qualified by CLK_EN.
module sys_bitlatch_array #(
    parameter int                      ADDR_W    = 3,
    parameter logic [(1<<ADDR_W)-1:0]  RESET_VAL = '0,
    parameter bit                      EDGE_MODE = 1'b0
) (
    input  logic                  CLK,
    input  logic                  nRESET,
    input  logic                  CLK_EN,
    sys_bitlatch_array_if.slave   bus
);
    localparam int N = 1 << ADDR_W;

    // State registers. Initialisers give the documented power-up image
    // before the first enabled edge; wr_prev starts high so an edge-mode
    // strobe already low at power-up counts as a fresh assertion.
    logic [N-1:0]      q_q         = RESET_VAL;
    logic              changed_q   = 1'b0;
    logic [ADDR_W-1:0] last_addr_q = '0;
    logic              wr_prev_q   = 1'b1;

    logic [N-1:0]      q_d;
    logic              changed_d;
    logic [ADDR_W-1:0] last_addr_d;
    logic              wr_prev_d;

    // Write qualifier: level mode accepts every low-strobe cycle; edge
    // mode additionally needs the previously sampled strobe to be high.
    logic              wr_qual;

    // Qualify the incoming strobe against the stored strobe history.
    always_comb begin
        wr_qual = 1'b0;
        if (EDGE_MODE) begin
            wr_qual = ~bus.nWR & wr_prev_q;
        end else begin
            wr_qual = ~bus.nWR;
        end
    end

    // Next-state: reset/demux has priority over the normal latch merge.
    always_comb begin
        q_d         = q_q;
        changed_d   = 1'b0;
        last_addr_d = last_addr_q;
        // Strobe history is sampled on every enabled edge, reset or not,
        // so a strobe held low through reset release is not a new edge.
        wr_prev_d   = bus.nWR;

        if (!nRESET) begin
            q_d       = RESET_VAL;
            changed_d = 1'b0;
            if (!bus.nWR) begin
                // Demux is level-sensitive in both modes.
                q_d[bus.ADDR] = bus.DIN;
                last_addr_d   = bus.ADDR;
            end else begin
                last_addr_d   = '0;
            end
        end else if (wr_qual) begin
            q_d[bus.ADDR] = bus.DIN;
            last_addr_d   = bus.ADDR;
            changed_d     = (q_q[bus.ADDR] != bus.DIN);
        end
    end

    // State update, held completely while CLK_EN is low.
    always_ff @(posedge CLK) begin
        if (CLK_EN) begin
            q_q         <= q_d;
            changed_q   <= changed_d;
            last_addr_q <= last_addr_d;
            wr_prev_q   <= wr_prev_d;
        end
    end

    assign bus.Q         = q_q;
    assign bus.CHANGED   = changed_q;
    assign bus.LAST_ADDR = last_addr_q;

endmodule

// File: tb/tb_sys_bitlatch_array.sv
// Bench for sys_bitlatch_array. Three instances share one stimulus
// stream: d0 = level mode with reset image 8'hA5, d1 = level mode with
// zero image, d2 = edge mode with zero image. A reference model predicts
// each instance's outputs per clock; predictions are queued when the
// stimulus is applied and compared after the edge. Directed checks pin
// the documented scenarios with hand-derived constants.
module tb_sys_bitlatch_array;

    localparam int ADDR_W = 3;
    localparam int N      = 1 << ADDR_W;
    localparam int W      = N + 1 + ADDR_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              nrst  = 1'b0;
    logic              en    = 1'b1;
    logic [ADDR_W-1:0] addr  = '0;
    logic              din   = 1'b0;
    logic              nwr   = 1'b1;

    sys_bitlatch_array_if #(.ADDR_W(ADDR_W)) bus0 ();
    sys_bitlatch_array_if #(.ADDR_W(ADDR_W)) bus1 ();
    sys_bitlatch_array_if #(.ADDR_W(ADDR_W)) bus2 ();

    assign bus0.ADDR = addr;  assign bus0.DIN = din;  assign bus0.nWR = nwr;
    assign bus1.ADDR = addr;  assign bus1.DIN = din;  assign bus1.nWR = nwr;
    assign bus2.ADDR = addr;  assign bus2.DIN = din;  assign bus2.nWR = nwr;

    sys_bitlatch_array #(.ADDR_W(ADDR_W), .RESET_VAL(8'hA5), .EDGE_MODE(1'b0)) dut0 (
        .CLK(clk), .nRESET(nrst), .CLK_EN(en), .bus(bus0.slave));
    sys_bitlatch_array #(.ADDR_W(ADDR_W), .RESET_VAL(8'h00), .EDGE_MODE(1'b0)) dut1 (
        .CLK(clk), .nRESET(nrst), .CLK_EN(en), .bus(bus1.slave));
    sys_bitlatch_array #(.ADDR_W(ADDR_W), .RESET_VAL(8'h00), .EDGE_MODE(1'b1)) dut2 (
        .CLK(clk), .nRESET(nrst), .CLK_EN(en), .bus(bus2.slave));

    // ---------------- counters / check ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0]      m_rv [3] = '{8'hA5, 8'h00, 8'h00};
    bit                m_em [3] = '{1'b0, 1'b0, 1'b1};
    logic [N-1:0]      m_q  [3] = '{8'hA5, 8'h00, 8'h00};
    logic              m_ch [3] = '{1'b0, 1'b0, 1'b0};
    logic [ADDR_W-1:0] m_la [3] = '{3'd0, 3'd0, 3'd0};
    logic              m_pv [3] = '{1'b1, 1'b1, 1'b1};

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q2[$];

    // Advance model instance i by one clock using the current inputs.
    task automatic model_step(input int i);
        logic commit;
        if (!en) return;
        if (!nrst) begin
            m_q[i]  = m_rv[i];
            m_ch[i] = 1'b0;
            m_la[i] = '0;
            if (!nwr) begin
                m_q[i][addr] = din;
                m_la[i]      = addr;
            end
        end else begin
            commit = !nwr && (!m_em[i] || m_pv[i]);
            m_ch[i] = commit && (m_q[i][addr] != din);
            if (commit) begin
                m_q[i][addr] = din;
                m_la[i]      = addr;
            end
        end
        m_pv[i] = nwr;
    endtask

    // ---------------- driver: one clock with scoreboard ----------------
    int n_tick = 0;
    task automatic tick();
        logic [W-1:0] e;
        for (int i = 0; i < 3; i++) model_step(i);
        exp_q0.push_back({m_q[0], m_ch[0], m_la[0]});
        exp_q1.push_back({m_q[1], m_ch[1], m_la[1]});
        exp_q2.push_back({m_q[2], m_ch[2], m_la[2]});
        @(posedge clk);
        #1;
        n_tick++;
        if (exp_q0.size() == 0 || exp_q1.size() == 0 || exp_q2.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q0.pop_front();
            check_val($sformatf("sb_d0_%0d", n_tick), {20'd0, bus0.Q, bus0.CHANGED, bus0.LAST_ADDR}, {20'd0, e});
            e = exp_q1.pop_front();
            check_val($sformatf("sb_d1_%0d", n_tick), {20'd0, bus1.Q, bus1.CHANGED, bus1.LAST_ADDR}, {20'd0, e});
            e = exp_q2.pop_front();
            check_val($sformatf("sb_d2_%0d", n_tick), {20'd0, bus2.Q, bus2.CHANGED, bus2.LAST_ADDR}, {20'd0, e});
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic w,
                         input logic [ADDR_W-1:0] a, input logic d);
        nrst = r; en = e; nwr = w; addr = a; din = d;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1;
        // Power-up image before any enabled edge.
        check_val("pwr_q0",  {24'd0, bus0.Q}, 32'hA5);
        check_val("pwr_ch1", {31'd0, bus1.CHANGED}, 32'd0);
        check_val("pwr_la2", {29'd0, bus2.LAST_ADDR}, 32'd0);

        // Reset clear.
        drive(1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        check_val("rst_q0",  {24'd0, bus0.Q}, 32'hA5);
        check_val("rst_ch0", {31'd0, bus0.CHANGED}, 32'd0);
        check_val("rst_la0", {29'd0, bus0.LAST_ADDR}, 32'd0);

        // Demux in reset, then clear again.
        drive(1'b0, 1'b1, 1'b0, 3'd5, 1'b1);
        check_val("dmx_q1",  {24'd0, bus1.Q}, 32'h20);
        check_val("dmx_la1", {29'd0, bus1.LAST_ADDR}, 32'd5);
        drive(1'b0, 1'b1, 1'b1, 3'd5, 1'b1);
        check_val("dmx_clr_q1", {24'd0, bus1.Q}, 32'h00);

        // Release reset, then three consecutive low-strobe writes.
        drive(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 3'd2, 1'b1);
        check_val("lvl_ch_a", {31'd0, bus1.CHANGED}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 3'd3, 1'b1);
        check_val("lvl_ch_b", {31'd0, bus1.CHANGED}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 3'd7, 1'b1);
        check_val("lvl_ch_c", {31'd0, bus1.CHANGED}, 32'd1);
        check_val("lvl_q1",   {24'd0, bus1.Q}, 32'h8C);
        check_val("edg_q2",   {24'd0, bus2.Q}, 32'h04);
        check_val("lvl_q0",   {24'd0, bus0.Q}, 32'hAD);
        drive(1'b1, 1'b1, 1'b1, 3'd7, 1'b1);
        check_val("lvl_ch_off", {31'd0, bus1.CHANGED}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 3'd7, 1'b1);
        check_val("edg_q2_b",  {24'd0, bus2.Q}, 32'h84);
        check_val("edg_ch2",   {31'd0, bus2.CHANGED}, 32'd1);
        check_val("nochg_ch1", {31'd0, bus1.CHANGED}, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 3'd7, 1'b1);

        // Clock-enable stall right after a committed write.
        drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
        check_val("stl_pre_q1", {24'd0, bus1.Q}, 32'h8D);
        for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'b1);
        check_val("stl_q1",  {24'd0, bus1.Q}, 32'h8D);
        check_val("stl_ch1", {31'd0, bus1.CHANGED}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 3'd1, 1'b1);
        check_val("stl_post_q1", {24'd0, bus1.Q}, 32'h8F);
        check_val("stl_post_q2", {24'd0, bus2.Q}, 32'h85);
        drive(1'b1, 1'b1, 1'b1, 3'd1, 1'b1);

        // Rewriting a bit with its current value.
        drive(1'b1, 1'b1, 1'b0, 3'd4, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 3'd4, 1'b1);
        check_val("same_q1",  {24'd0, bus1.Q}, 32'h9F);
        check_val("same_ch1", {31'd0, bus1.CHANGED}, 32'd0);
        check_val("same_la1", {29'd0, bus1.LAST_ADDR}, 32'd4);
        drive(1'b1, 1'b1, 1'b1, 3'd4, 1'b1);

        // Edge mode: strobe held low through reset release.
        drive(1'b0, 1'b1, 1'b0, 3'd3, 1'b1);
        check_val("rel_dmx_q2", {24'd0, bus2.Q}, 32'h08);
        drive(1'b1, 1'b1, 1'b0, 3'd6, 1'b1);
        check_val("rel_q2",  {24'd0, bus2.Q}, 32'h08);
        check_val("rel_la2", {29'd0, bus2.LAST_ADDR}, 32'd3);
        check_val("rel_q1",  {24'd0, bus1.Q}, 32'h48);
        drive(1'b1, 1'b1, 1'b1, 3'd6, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 3'd6, 1'b1);
        check_val("rel_q2_b", {24'd0, bus2.Q}, 32'h48);

        // Random traffic, scoreboard only.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 19) != 0),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sys_bitlatch_array.md
# sys_bitlatch_array

Parametrised addressable bit-latch array: the generalised successor of the 8-bit system control latch. The 68K sets or clears one control bit per write strobe by selecting it with address lines, with the data bit carried on another address line. The block adds configurable depth, a per-bit reset image, an optional edge-qualified write mode and a change-notify pulse. It sits in the I/O decode area on the 68K clock-enable domain and drives control bits such as bank selects, vector swap and write enables.

## Interface
Parameters:
- ADDR_W, 3, bit-select address width; latch depth N = 2**ADDR_W (1..6 legal).
- RESET_VAL, {N{1'b0}}, value loaded into Q by reset when no write is present.
- EDGE_MODE, 0, 0 = level latch (a write on every enabled cycle with nWR low); 1 = one write per nWR assertion.

Ports (reset nRESET, synchronous, active-low; clock CLK):
- CLK  in  1  system clock.
- nRESET  in  1  synchronous active-low reset; sampled only on CLK_EN cycles.
- CLK_EN  in  1  68K-phase clock enable; qualifies every state update.
- ADDR  in  ADDR_W  bit index to write.
- DIN  in  1  value written to Q[ADDR].
- nWR  in  1  active-low write strobe from the address decoder.
- Q  out  N  latch contents.
- CHANGED  out  1  pulse: the last committed write altered a bit.
- LAST_ADDR  out  ADDR_W  index of the most recent committed write.

## Operation
- All state changes occur on a rising CLK edge with CLK_EN=1. When CLK_EN=0, all registers hold, including the nWR history.
- wr_prev register: it samples nWR on every enabled edge, including during reset. Its reset value is undefined until the first enabled edge, so it is initialised to 1 at power-up.
- Write qualifier wr_q:
  - EDGE_MODE=0: wr_q = ~nWR.
  - EDGE_MODE=1: wr_q = ~nWR & wr_prev.
- Reset, nRESET=0, enabled edge:
  - If nWR=1 (clear): Q <= RESET_VAL, CHANGED <= 0, LAST_ADDR <= 0.
  - If nWR=0 (demux): Q <= RESET_VAL with bit ADDR replaced by DIN; LAST_ADDR <= ADDR; CHANGED <= 0.
  - Demux is level-sensitive in both modes.
- Normal operation, nRESET=1, enabled edge:
  - If wr_q=1 (latch): Q[ADDR] <= DIN; all other bits hold; LAST_ADDR <= ADDR; CHANGED <= (Q[ADDR] != DIN).
  - If wr_q=0: Q and LAST_ADDR hold; CHANGED <= 0.
- EDGE_MODE=1 with nWR held low across reset release: no write after release until nWR goes high, then low again, because wr_prev tracked the low level during reset.
- EDGE_MODE=0 with ADDR or DIN changing while nWR is low: every enabled cycle commits the current ADDR/DIN, giving transparent-latch behaviour.
- EDGE_MODE=1 with ADDR changing while nWR is low: only the first sampled address is written.
- Power-up before the first enabled edge: Q = RESET_VAL, CHANGED = 0, LAST_ADDR = 0 (register initialisers).

## Timing
- Write latency: Q is visible one CLK cycle after the enabled edge that sampled nWR low; no combinational path from inputs to Q.
- CHANGED is asserted from the committing enabled edge until the next enabled edge. Its width is therefore one CLK_EN period, not one CLK cycle.
- Reset-value output summary: Q = RESET_VAL (or the demux image), CHANGED = 0, LAST_ADDR = 0 (or ADDR in demux).
- Simultaneous reset and write: reset/demux has priority. The latch-mode merge never occurs while nRESET=0.
- Back-to-back writes on consecutive enabled cycles are all committed in EDGE_MODE=0. In EDGE_MODE=1 they require an intervening sampled nWR=1.

## Test plan
- Reset clear: RESET_VAL=8'hA5, nRESET=0, nWR=1, one enabled edge -> Q=8'hA5, CHANGED=0, LAST_ADDR=0.
- Demux in reset: RESET_VAL=0, nRESET=0, nWR=0, ADDR=5, DIN=1 -> Q=8'h20, LAST_ADDR=5; then nWR=1 -> Q=8'h00.
- Level latch: EDGE_MODE=0, Q=0, nWR low for 3 enabled edges with ADDR=2,3,7 and DIN=1 -> Q=8'h8C. CHANGED is high for each of the 3 periods, then low.
- Edge latch: EDGE_MODE=1, nWR low for the same 3 edges with ADDR=2,3,7 -> Q=8'h04 only; after nWR=1 and then nWR=0 with ADDR=7 -> Q=8'h84.
- CLK_EN stall: CLK_EN=0 for 10 cycles while nWR=0 -> Q unchanged, CHANGED held. The first enabled edge then performs exactly one write.
- No-change write: Q[4]=1, write ADDR=4, DIN=1 -> Q unchanged, CHANGED=0, LAST_ADDR=4. EDGE_MODE=1 with nWR held low through reset release -> no write after release.
